rs: RTL and testbench
=====================

# rs

Reservation station for the integer/branch/jump path of the out-of-order core. It sits between dispatch and the ALU. It buffers up to `RS_SIZE` decoded instructions and tracks their pending source tags against the ALU and LSB result broadcasts. Each cycle it sends at most one fully-ready instruction to the ALU, with operands and metadata registered.

## Interface
- `RS_SIZE`, 8: number of entries (power of two, ≥2).
- `RS_IDX_W`, 3: log2(`RS_SIZE`).

- `clk` in 1: the only clock; all state updates on posedge.
- `rst` in 1: synchronous, active-high reset.
- `rdy` in 1: global ready; when 0, all state and outputs hold.
- `rollback_config` in 1: misprediction flush; synchronous clear, same effect as `rst`.
- `in_config` in 1: dispatch valid for this cycle.
- `in_opcode` in 7, `in_precise` in 3, `in_more_precise` in 1: decoded op (funct3, funct7[5]).
- `in_imm` in 32, `in_PC` in 32, `in_rob_entry` in 4: immediate, instruction PC, destination ROB tag.
- `in_Vj`, `in_Vk` in 32: source values, valid when the matching Q-valid bit is 0.
- `in_Qj_valid`, `in_Qk_valid` in 1; `in_Qj`, `in_Qk` in 4: pending producer ROB tags.
- `alu_cdb_config` in 1, `alu_cdb_rob_entry` in 4, `alu_cdb_val` in 32: ALU result broadcast.
- `lsb_cdb_config` in 1, `lsb_cdb_rob_entry` in 4, `lsb_cdb_val` in 32: load/store buffer result broadcast.
- `out_full` out 1: combinational; 1 when all entries are busy.
- `out_alu_config` out 1: issue valid, one-cycle pulse per issued instruction.
- `out_a`, `out_b` out 32: rs1 and rs2 values.
- `out_PC`, `out_opcode`, `out_precise`, `out_more_precise`, `out_imm`, `out_rob_entry` out: entry fields, same widths as the inputs.

## Operation
- Entry state: busy, opcode, precise, more_precise, imm, PC, rob_entry, Vj, Vk, Qj_valid, Qj, Qk_valid, Qk.
- **Allocate.**
  - With `in_config=1` and `out_full=0`, write the lowest-index non-busy entry and set busy.
  - `out_full` is computed from current busy bits only; a same-cycle issue does not unblock it.
  - `in_config=1` while full is ignored and is a protocol violation; the bench flags it.
- **Dispatch bypass.**
  - If `in_Qj_valid` and a CDB broadcast with tag == `in_Qj` is valid in the same cycle, store that value in Vj and clear Qj_valid.
  - Qk behaves the same way.
  - The ALU CDB and the LSB CDB are both checked.
- **Wakeup.**
  - Every busy entry whose Qj_valid (Qk_valid) is set and whose Qj (Qk) matches a valid CDB tag captures the value and clears the valid bit.
  - One broadcast may wake both Qj and Qk of the same entry, and may wake any number of entries.
  - The two CDBs never carry the same tag in the same cycle, since ROB tags are unique.
- **Select.**
  - Ready = busy & !Qj_valid & !Qk_valid, evaluated on register state at cycle start.
  - The lowest-index ready entry is chosen.
  - An entry written or woken this cycle is not eligible until the next cycle.
- **Issue.**
  - Drive all entry fields to the outputs (Vj→`out_a`, Vk→`out_b`), set `out_alu_config=1`, and clear the entry's busy bit, all on the same edge.
  - If no entry is ready, `out_alu_config=0` and the data outputs hold their last values.
- Instructions without rs1 or rs2 (LUI, AUIPC, JAL, I-type) arrive from dispatch with the corresponding Q-valid bit already 0; the RS never interprets the opcode.
- A freed entry may be reallocated on the same edge: issue and allocate target different entries because allocation uses start-of-cycle busy bits.

## Timing
- **Reset / rollback.** `rst=1` or `rollback_config=1` at an edge:
  - all busy bits go to 0 and all outputs go to 0, including `out_alu_config=0`;
  - a dispatch or CDB in the same cycle is discarded;
  - this takes priority over `rdy`.
- **Latency.**
  - Dispatch with both operands ready at edge N: entry valid after N; `out_alu_config=1` after N+1; ALU result after N+2.
  - Operand woken by a CDB at edge N: issue after N+1 at the earliest.
  - Dispatch bypass follows the same rule: data captured at N, issue after N+1.
- **Throughput.** One issue per cycle maximum.
- **Stall.** `rdy=0`: no allocate, wakeup, issue or output change.
  - CDB producers also hold under `rdy=0`, so no broadcast is lost.
  - `out_alu_config` keeps its value; the ALU also holds under `rdy=0`.
- **Mid-operation reset.** Any entry in any state is dropped; the first issue after release requires a new dispatch.

## Test plan
- Reset, then dispatch ADDI (Qj_valid=0, Vj=5, imm=7, rob=3) → `out_alu_config=1` two edges later with `out_a`=5, `out_imm`=7, `out_rob_entry`=3, and a one-cycle pulse only.
- Dispatch ADD with Qj=2 pending and Vk=10; three cycles later `alu_cdb` (tag 2, val 0x20) → issue one edge after the broadcast with `out_a`=0x20, `out_b`=10.
- Dispatch with Qj=Qk=6 in the same cycle `lsb_cdb` broadcasts tag 6, val 0xFFFF_FFFF (bypass) → issue next edge with `out_a`=`out_b`=0xFFFF_FFFF.
- Fill all 8 entries with unready ops → `out_full=1` and a further `in_config` is ignored; wake entries 5 and 2 together → entry 2 issues first, entry 5 the next cycle, and `out_full` drops the cycle after the first issue.
- Hold `rdy=0` for 4 cycles with a ready entry present → no issue and outputs frozen; on `rdy=1` the issue occurs on the next edge.
- 4 busy entries, assert `rollback_config` in the same cycle as a dispatch and a CDB → next cycle `out_full=0`, `out_alu_config=0` and no later issues; re-dispatch works normally.

Source files
------------

// File: rtl/rs.sv
// Reservation station for the integer/branch/jump path: buffers dispatched ops,
// wakes pending operands from the ALU/LSB broadcasts and issues one ready op per cycle.
module rs #(
    parameter int RS_SIZE  = 8,
    parameter int RS_IDX_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_config,
    input  logic        in_config,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_precise,
    input  logic        in_more_precise,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_PC,
    input  logic [3:0]  in_rob_entry,
    input  logic [31:0] in_Vj,
    input  logic [31:0] in_Vk,
    input  logic        in_Qj_valid,
    input  logic        in_Qk_valid,
    input  logic [3:0]  in_Qj,
    input  logic [3:0]  in_Qk,
    input  logic        alu_cdb_config,
    input  logic [3:0]  alu_cdb_rob_entry,
    input  logic [31:0] alu_cdb_val,
    input  logic        lsb_cdb_config,
    input  logic [3:0]  lsb_cdb_rob_entry,
    input  logic [31:0] lsb_cdb_val,
    output logic        out_full,
    output logic        out_alu_config,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [31:0] out_PC,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_precise,
    output logic        out_more_precise,
    output logic [31:0] out_imm,
    output logic [3:0]  out_rob_entry
);

    logic        r_busy         [RS_SIZE];
    logic [6:0]  r_opcode       [RS_SIZE];
    logic [2:0]  r_precise      [RS_SIZE];
    logic        r_more_precise [RS_SIZE];
    logic [31:0] r_imm          [RS_SIZE];
    logic [31:0] r_pc           [RS_SIZE];
    logic [3:0]  r_rob_entry    [RS_SIZE];
    logic [31:0] r_vj           [RS_SIZE];
    logic [31:0] r_vk           [RS_SIZE];
    logic        r_qj_valid     [RS_SIZE];
    logic        r_qk_valid     [RS_SIZE];
    logic [3:0]  r_qj           [RS_SIZE];
    logic [3:0]  r_qk           [RS_SIZE];

    logic                w_full;
    logic                w_alloc_found;
    logic [RS_IDX_W-1:0] w_alloc_idx;
    logic                w_issue_found;
    logic [RS_IDX_W-1:0] w_issue_idx;
    logic [31:0]         w_in_vj;
    logic [31:0]         w_in_vk;
    logic                w_in_qj_valid;
    logic                w_in_qk_valid;

    // Both priority encoders look only at start-of-cycle state, so allocate and
    // issue never pick the same entry.
    always_comb begin
        w_full        = 1'b1;
        w_alloc_found = 1'b0;
        w_alloc_idx   = '0;
        w_issue_found = 1'b0;
        w_issue_idx   = '0;
        for (int unsigned i = 0; i < RS_SIZE; i++) begin
            if (!r_busy[i]) begin
                w_full = 1'b0;
                if (!w_alloc_found) begin
                    w_alloc_found = 1'b1;
                    w_alloc_idx   = RS_IDX_W'(i);
                end
            end
            if (r_busy[i] && !r_qj_valid[i] && !r_qk_valid[i] && !w_issue_found) begin
                w_issue_found = 1'b1;
                w_issue_idx   = RS_IDX_W'(i);
            end
        end
    end

    always_comb begin
        w_in_vj       = in_Vj;
        w_in_qj_valid = in_Qj_valid;
        w_in_vk       = in_Vk;
        w_in_qk_valid = in_Qk_valid;
        if (in_Qj_valid && alu_cdb_config && alu_cdb_rob_entry == in_Qj) begin
            w_in_vj       = alu_cdb_val;
            w_in_qj_valid = 1'b0;
        end else if (in_Qj_valid && lsb_cdb_config && lsb_cdb_rob_entry == in_Qj) begin
            w_in_vj       = lsb_cdb_val;
            w_in_qj_valid = 1'b0;
        end
        if (in_Qk_valid && alu_cdb_config && alu_cdb_rob_entry == in_Qk) begin
            w_in_vk       = alu_cdb_val;
            w_in_qk_valid = 1'b0;
        end else if (in_Qk_valid && lsb_cdb_config && lsb_cdb_rob_entry == in_Qk) begin
            w_in_vk       = lsb_cdb_val;
            w_in_qk_valid = 1'b0;
        end
    end

    assign out_full = w_full;

    always_ff @(posedge clk) begin
        if (rst || rollback_config) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                r_busy[i] <= 1'b0;
            end
            out_alu_config   <= 1'b0;
            out_a            <= '0;
            out_b            <= '0;
            out_PC           <= '0;
            out_opcode       <= '0;
            out_precise      <= '0;
            out_more_precise <= 1'b0;
            out_imm          <= '0;
            out_rob_entry    <= '0;
        end else if (rdy) begin
            for (int unsigned i = 0; i < RS_SIZE; i++) begin
                if (r_busy[i] && r_qj_valid[i]) begin
                    if (alu_cdb_config && alu_cdb_rob_entry == r_qj[i]) begin
                        r_vj[i]       <= alu_cdb_val;
                        r_qj_valid[i] <= 1'b0;
                    end else if (lsb_cdb_config && lsb_cdb_rob_entry == r_qj[i]) begin
                        r_vj[i]       <= lsb_cdb_val;
                        r_qj_valid[i] <= 1'b0;
                    end
                end
                if (r_busy[i] && r_qk_valid[i]) begin
                    if (alu_cdb_config && alu_cdb_rob_entry == r_qk[i]) begin
                        r_vk[i]       <= alu_cdb_val;
                        r_qk_valid[i] <= 1'b0;
                    end else if (lsb_cdb_config && lsb_cdb_rob_entry == r_qk[i]) begin
                        r_vk[i]       <= lsb_cdb_val;
                        r_qk_valid[i] <= 1'b0;
                    end
                end
            end

            out_alu_config <= w_issue_found;
            if (w_issue_found) begin
                out_a                  <= r_vj[w_issue_idx];
                out_b                  <= r_vk[w_issue_idx];
                out_PC                 <= r_pc[w_issue_idx];
                out_opcode             <= r_opcode[w_issue_idx];
                out_precise            <= r_precise[w_issue_idx];
                out_more_precise       <= r_more_precise[w_issue_idx];
                out_imm                <= r_imm[w_issue_idx];
                out_rob_entry          <= r_rob_entry[w_issue_idx];
                r_busy[w_issue_idx]    <= 1'b0;
            end

            if (in_config && !w_full) begin
                r_busy[w_alloc_idx]         <= 1'b1;
                r_opcode[w_alloc_idx]       <= in_opcode;
                r_precise[w_alloc_idx]      <= in_precise;
                r_more_precise[w_alloc_idx] <= in_more_precise;
                r_imm[w_alloc_idx]          <= in_imm;
                r_pc[w_alloc_idx]           <= in_PC;
                r_rob_entry[w_alloc_idx]    <= in_rob_entry;
                r_vj[w_alloc_idx]           <= w_in_vj;
                r_vk[w_alloc_idx]           <= w_in_vk;
                r_qj_valid[w_alloc_idx]     <= w_in_qj_valid;
                r_qk_valid[w_alloc_idx]     <= w_in_qk_valid;
                r_qj[w_alloc_idx]           <= in_Qj;
                r_qk[w_alloc_idx]           <= in_Qk;
            end
        end
    end

endmodule

// File: tb/tb_rs.sv
// Directed-vector bench for the reservation station: one task per scenario,
// inputs driven 1 time unit after each rising edge, outputs sampled there too.
module tb_rs;

    logic        clk = 1'b0;
    logic        rst, rdy, rollback_config, in_config;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic [31:0] in_imm, in_PC;
    logic [3:0]  in_rob_entry;
    logic [31:0] in_Vj, in_Vk;
    logic        in_Qj_valid, in_Qk_valid;
    logic [3:0]  in_Qj, in_Qk;
    logic        alu_cdb_config, lsb_cdb_config;
    logic [3:0]  alu_cdb_rob_entry, lsb_cdb_rob_entry;
    logic [31:0] alu_cdb_val, lsb_cdb_val;
    logic        out_full, out_alu_config, out_more_precise;
    logic [31:0] out_a, out_b, out_PC, out_imm;
    logic [6:0]  out_opcode;
    logic [2:0]  out_precise;
    logic [3:0]  out_rob_entry;

    int passed = 0;
    int total  = 0;
    int violations = 0;

    rs #(.RS_SIZE(8), .RS_IDX_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback_config(rollback_config),
        .in_config(in_config), .in_opcode(in_opcode), .in_precise(in_precise),
        .in_more_precise(in_more_precise), .in_imm(in_imm), .in_PC(in_PC),
        .in_rob_entry(in_rob_entry), .in_Vj(in_Vj), .in_Vk(in_Vk),
        .in_Qj_valid(in_Qj_valid), .in_Qk_valid(in_Qk_valid), .in_Qj(in_Qj), .in_Qk(in_Qk),
        .alu_cdb_config(alu_cdb_config), .alu_cdb_rob_entry(alu_cdb_rob_entry),
        .alu_cdb_val(alu_cdb_val), .lsb_cdb_config(lsb_cdb_config),
        .lsb_cdb_rob_entry(lsb_cdb_rob_entry), .lsb_cdb_val(lsb_cdb_val),
        .out_full(out_full), .out_alu_config(out_alu_config), .out_a(out_a), .out_b(out_b),
        .out_PC(out_PC), .out_opcode(out_opcode), .out_precise(out_precise),
        .out_more_precise(out_more_precise), .out_imm(out_imm), .out_rob_entry(out_rob_entry)
    );

    always #5 clk = ~clk;

    // Dispatching into a full station is a protocol violation.
    always @(posedge clk) begin
        if (in_config && out_full && rdy && !rst && !rollback_config) begin
            violations++;
            $display("protocol violation: in_config while out_full at %0t", $time);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_config = 0; in_opcode = 0; in_precise = 0; in_more_precise = 0;
        in_imm = 0; in_PC = 0; in_rob_entry = 0; in_Vj = 0; in_Vk = 0;
        in_Qj_valid = 0; in_Qk_valid = 0; in_Qj = 0; in_Qk = 0;
        alu_cdb_config = 0; alu_cdb_rob_entry = 0; alu_cdb_val = 0;
        lsb_cdb_config = 0; lsb_cdb_rob_entry = 0; lsb_cdb_val = 0;
    endtask

    task automatic drive_disp(input logic [3:0] rob, input logic [31:0] vj, input logic [31:0] vk,
                              input logic [31:0] imm, input logic qjv, input logic [3:0] qj,
                              input logic qkv, input logic [3:0] qk);
        in_config = 1; in_opcode = 7'h33; in_precise = 3'd0; in_more_precise = 1'b0;
        in_rob_entry = rob; in_Vj = vj; in_Vk = vk; in_imm = imm; in_PC = 32'h1000 + {28'd0, rob};
        in_Qj_valid = qjv; in_Qj = qj; in_Qk_valid = qkv; in_Qk = qk;
    endtask

    task automatic do_reset();
        idle_inputs();
        rdy = 1; rollback_config = 0; rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_full !== 1'b0) $display("FAIL reset_full: got %b expected 0", out_full); else passed++;
        total++; if (out_alu_config !== 1'b0) $display("FAIL reset_cfg: got %b expected 0", out_alu_config); else passed++;
        total++; if (out_a !== 32'h0) $display("FAIL reset_a: got %h expected 0", out_a); else passed++;
        total++; if (out_rob_entry !== 4'h0) $display("FAIL reset_rob: got %h expected 0", out_rob_entry); else passed++;
    endtask

    task automatic test_addi();
        do_reset();
        drive_disp(4'd3, 32'd5, 32'd0, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
        in_opcode = 7'h13; in_precise = 3'd0;
        step();
        idle_inputs();
        total++; if (out_alu_config !== 1'b0) $display("FAIL addi_early: got %b expected 0", out_alu_config); else passed++;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL addi_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_a !== 32'd5) $display("FAIL addi_a: got %h expected 5", out_a); else passed++;
        total++; if (out_imm !== 32'd7) $display("FAIL addi_imm: got %h expected 7", out_imm); else passed++;
        total++; if (out_rob_entry !== 4'd3) $display("FAIL addi_rob: got %h expected 3", out_rob_entry); else passed++;
        total++; if (out_opcode !== 7'h13) $display("FAIL addi_op: got %h expected 13", out_opcode); else passed++;
        total++; if (out_PC !== 32'h1003) $display("FAIL addi_pc: got %h expected 1003", out_PC); else passed++;
        step();
        total++; if (out_alu_config !== 1'b0) $display("FAIL addi_pulse: got %b expected 0", out_alu_config); else passed++;
        total++; if (out_a !== 32'd5) $display("FAIL addi_hold: got %h expected 5", out_a); else passed++;
    endtask

    task automatic test_wakeup();
        do_reset();
        drive_disp(4'd4, 32'd0, 32'd10, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0);
        step();
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            step();
            total++; if (out_alu_config !== 1'b0) $display("FAIL wake_wait%0d: got %b expected 0", c, out_alu_config); else passed++;
        end
        alu_cdb_config = 1; alu_cdb_rob_entry = 4'd2; alu_cdb_val = 32'h20;
        step();
        idle_inputs();
        total++; if (out_alu_config !== 1'b0) $display("FAIL wake_same: got %b expected 0", out_alu_config); else passed++;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL wake_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_a !== 32'h20) $display("FAIL wake_a: got %h expected 20", out_a); else passed++;
        total++; if (out_b !== 32'd10) $display("FAIL wake_b: got %h expected a", out_b); else passed++;
        total++; if (out_rob_entry !== 4'd4) $display("FAIL wake_rob: got %h expected 4", out_rob_entry); else passed++;
    endtask

    task automatic test_bypass();
        do_reset();
        drive_disp(4'd7, 32'd0, 32'd0, 32'd0, 1'b1, 4'd6, 1'b1, 4'd6);
        lsb_cdb_config = 1; lsb_cdb_rob_entry = 4'd6; lsb_cdb_val = 32'hFFFF_FFFF;
        step();
        idle_inputs();
        total++; if (out_alu_config !== 1'b0) $display("FAIL byp_early: got %b expected 0", out_alu_config); else passed++;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL byp_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_a !== 32'hFFFF_FFFF) $display("FAIL byp_a: got %h expected ffffffff", out_a); else passed++;
        total++; if (out_b !== 32'hFFFF_FFFF) $display("FAIL byp_b: got %h expected ffffffff", out_b); else passed++;
        total++; if (out_rob_entry !== 4'd7) $display("FAIL byp_rob: got %h expected 7", out_rob_entry); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        // Entry i waits on tag i and carries rob i+8, Vk=i.
        for (int i = 0; i < 8; i++) begin
            drive_disp(4'(i + 8), 32'd0, 32'(i), 32'd0, 1'b1, 4'(i), 1'b0, 4'd0);
            step();
        end
        idle_inputs();
        total++; if (out_full !== 1'b1) $display("FAIL full_set: got %b expected 1", out_full); else passed++;
        drive_disp(4'd1, 32'h99, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        idle_inputs();
        total++; if (violations !== 1) $display("FAIL full_flag: got %0d expected 1", violations); else passed++;
        step();
        total++; if (out_alu_config !== 1'b0) $display("FAIL full_ignored: got %b expected 0", out_alu_config); else passed++;
        total++; if (out_full !== 1'b1) $display("FAIL full_still: got %b expected 1", out_full); else passed++;
        alu_cdb_config = 1; alu_cdb_rob_entry = 4'd2; alu_cdb_val = 32'h222;
        lsb_cdb_config = 1; lsb_cdb_rob_entry = 4'd5; lsb_cdb_val = 32'h555;
        step();
        idle_inputs();
        total++; if (out_alu_config !== 1'b0) $display("FAIL full_wake_same: got %b expected 0", out_alu_config); else passed++;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL full_iss1_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_rob_entry !== 4'd10) $display("FAIL full_iss1_rob: got %h expected a", out_rob_entry); else passed++;
        total++; if (out_a !== 32'h222) $display("FAIL full_iss1_a: got %h expected 222", out_a); else passed++;
        total++; if (out_b !== 32'd2) $display("FAIL full_iss1_b: got %h expected 2", out_b); else passed++;
        total++; if (out_full !== 1'b0) $display("FAIL full_drop: got %b expected 0", out_full); else passed++;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL full_iss2_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_rob_entry !== 4'd13) $display("FAIL full_iss2_rob: got %h expected d", out_rob_entry); else passed++;
        total++; if (out_a !== 32'h555) $display("FAIL full_iss2_a: got %h expected 555", out_a); else passed++;
        step();
        total++; if (out_alu_config !== 1'b0) $display("FAIL full_done: got %b expected 0", out_alu_config); else passed++;
    endtask

    task automatic test_stall();
        do_reset();
        drive_disp(4'd5, 32'h55, 32'h66, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        idle_inputs();
        rdy = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            total++; if (out_alu_config !== 1'b0) $display("FAIL stall_cfg%0d: got %b expected 0", c, out_alu_config); else passed++;
            total++; if (out_a !== 32'h0) $display("FAIL stall_a%0d: got %h expected 0", c, out_a); else passed++;
        end
        rdy = 1;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL stall_rel_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_a !== 32'h55) $display("FAIL stall_rel_a: got %h expected 55", out_a); else passed++;
        total++; if (out_rob_entry !== 4'd5) $display("FAIL stall_rel_rob: got %h expected 5", out_rob_entry); else passed++;
        rdy = 0;
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL stall_hold_cfg: got %b expected 1", out_alu_config); else passed++;
        rdy = 1;
        step();
        total++; if (out_alu_config !== 1'b0) $display("FAIL stall_after: got %b expected 0", out_alu_config); else passed++;
    endtask

    task automatic test_rollback();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive_disp(4'(i), 32'd0, 32'd0, 32'd0, 1'b1, 4'd1, 1'b0, 4'd0);
            step();
        end
        idle_inputs();
        step();
        drive_disp(4'd9, 32'h77, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        alu_cdb_config = 1; alu_cdb_rob_entry = 4'd1; alu_cdb_val = 32'h7;
        rollback_config = 1;
        step();
        idle_inputs();
        rollback_config = 0;
        total++; if (out_full !== 1'b0) $display("FAIL rb_full: got %b expected 0", out_full); else passed++;
        total++; if (out_alu_config !== 1'b0) $display("FAIL rb_cfg: got %b expected 0", out_alu_config); else passed++;
        for (int c = 0; c < 3; c++) begin
            step();
            total++; if (out_alu_config !== 1'b0) $display("FAIL rb_quiet%0d: got %b expected 0", c, out_alu_config); else passed++;
        end
        drive_disp(4'd6, 32'h66, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
        step();
        idle_inputs();
        step();
        total++; if (out_alu_config !== 1'b1) $display("FAIL rb_redisp_cfg: got %b expected 1", out_alu_config); else passed++;
        total++; if (out_a !== 32'h66) $display("FAIL rb_redisp_a: got %h expected 66", out_a); else passed++;
        total++; if (out_rob_entry !== 4'd6) $display("FAIL rb_redisp_rob: got %h expected 6", out_rob_entry); else passed++;
    endtask

    initial begin
        idle_inputs();
        rst = 1; rdy = 1; rollback_config = 0;
        #1;
        test_reset();
        test_addi();
        test_wakeup();
        test_bypass();
        test_full();
        test_stall();
        test_rollback();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
